// File: rtl/if_axi_bridge_pkg.sv
// Shared definitions for the instruction-fetch to AXI read bridge.
//   - FSM state encoding
//   - fetch request type and access size codes
//   - AXI response and burst codes
//   - size_mask(): keeps the low 1/2/4/8 bytes of a 64-bit word
package if_axi_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StData = 2'd2,
      StResp = 2'd3
   } state_e;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam logic [1:0] BURST_INCR = 2'b01;

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] mask;
      mask = '0;
      unique case (size)
         SIZE_B:  mask = 64'h0000_0000_0000_00ff;
         SIZE_H:  mask = 64'h0000_0000_0000_ffff;
         SIZE_W:  mask = 64'h0000_0000_ffff_ffff;
         SIZE_D:  mask = 64'hffff_ffff_ffff_ffff;
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/if_rdata_align.sv
// Read-data alignment: shifts the AXI beat right by the byte offset of the
// fetch address, then keeps only the requested access size (upper bits zero).
//   data    in  64  raw AXI read beat
//   offset  in  3   byte offset within the 64-bit beat (addr[2:0])
//   size    in  2   access size code (SIZE_B/H/W/D)
//   aligned out 64  right-aligned, size-masked data
module if_rdata_align
   import if_axi_bridge_pkg::*;
(
   input  logic [63:0] data,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   output logic [63:0] aligned
);

   logic [63:0] shifted;

   assign shifted = data >> {offset, 3'b000};
   assign aligned = shifted & size_mask(size);

endmodule

// File: rtl/if_axi_bridge.sv
// Instruction-fetch to AXI4 read bridge. Converts a single fetch request into
// one single-beat AXI read, returns right-aligned, size-masked data with a
// one-cycle if_ready pulse. Write requests are refused with SLVERR without
// any AXI traffic. At most one request is outstanding.
//   clk, rst                   clock, asynchronous active-low reset
//   if_valid/if_req/if_addr/if_size   fetch request
//   if_ready/if_data_read/if_resp     completion pulse, data and response
//   axi_ar_*                   AXI read-address channel (master side)
//   axi_r_*                    AXI read-data channel (master side)
module if_axi_bridge
   import if_axi_bridge_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h0,
   parameter logic [7:0] RD_LEN = 8'h00
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        if_valid,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   input  logic [1:0]  if_size,
   output logic        if_ready,
   output logic [63:0] if_data_read,
   output logic [1:0]  if_resp,

   output logic        axi_ar_valid,
   input  logic        axi_ar_ready,
   output logic [63:0] axi_ar_addr,
   output logic [3:0]  axi_ar_id,
   output logic [7:0]  axi_ar_len,
   output logic [2:0]  axi_ar_size,
   output logic [1:0]  axi_ar_burst,

   input  logic        axi_r_valid,
   output logic        axi_r_ready,
   input  logic [63:0] axi_r_data,
   input  logic [1:0]  axi_r_resp,
   input  logic        axi_r_last,
   input  logic [3:0]  axi_r_id
);

   state_e      state_q, state_d;
   logic [63:0] addr_q;
   logic [1:0]  size_q;
   logic [63:0] rdata_q;
   logic [1:0]  resp_q;
   logic [63:0] aligned;

   // Single-beat reads with a fixed ID: last and ID carry no information here.
   logic unused_r_fields;
   assign unused_r_fields = ^{axi_r_last, axi_r_id};

   if_rdata_align u_align (
      .data    (axi_r_data),
      .offset  (addr_q[2:0]),
      .size    (size_q),
      .aligned (aligned)
   );

   // Next state and handshake outputs.
   always_comb begin
      state_d      = state_q;
      axi_ar_valid = 1'b0;
      axi_r_ready  = 1'b0;
      if_ready     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (if_valid) begin
               state_d = (if_req == REQ_READ) ? StAddr : StResp;
            end
         end
         StAddr: begin
            axi_ar_valid = 1'b1;
            if (axi_ar_ready) begin
               state_d = StData;
            end
         end
         StData: begin
            axi_r_ready = 1'b1;
            if (axi_r_valid) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if_ready = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture: address/size only for reads; a write is answered
   // directly with SLVERR and zero data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         size_q <= SIZE_B;
      end else if (state_q == StIdle && if_valid && if_req == REQ_READ) begin
         addr_q <= if_addr;
         size_q <= if_size;
      end
   end

   // Result registers only change on a new result, so they hold outside RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         resp_q  <= RESP_OKAY;
      end else if (state_q == StIdle && if_valid && if_req == REQ_WRITE) begin
         rdata_q <= '0;
         resp_q  <= RESP_SLVERR;
      end else if (state_q == StData && axi_r_valid) begin
         rdata_q <= aligned;
         resp_q  <= axi_r_resp;
      end
   end

   assign if_data_read = rdata_q;
   assign if_resp      = resp_q;

   assign axi_ar_addr  = addr_q;
   assign axi_ar_size  = {1'b0, size_q};
   assign axi_ar_id    = AXI_ID;
   assign axi_ar_len   = RD_LEN;
   assign axi_ar_burst = BURST_INCR;

endmodule
